my_dispatch8: RTL and testbench
===============================

MY_DISPATCH8 -- requirements
Module: my_dispatch8

Interface
REQ-001 Parameter: WIDTH, default 16, payload width in bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream item present.
REQ-005 in_ready  output  1  block accepts the upstream item this cycle.
REQ-006 in_data  input  WIDTH  upstream payload.
REQ-007 en_mask  input  8  per-channel enable; bit i=1 means channel i is eligible.
REQ-008 out_valid  output  8  one-hot or zero; bit i marks the item offered to channel i.
REQ-009 out_ready  input  8  per-channel sink ready.
REQ-010 out_data  output  WIDTH  held payload, shared by all channels.
REQ-011 sel  output  3  channel index of the held item (the demux select).
REQ-012 busy  output  1  holding register full.
REQ-013 sent_cnt  output  16  count of completed downstream transfers.

Function
REQ-014 The block SHALL contain one holding register and two states: EMPTY and FULL. busy SHALL be 1 exactly in FULL.
REQ-015 Upstream accept ("load") SHALL occur at a clock edge where in_valid=1 and in_ready=1.
REQ-016 Downstream transfer ("fire") SHALL occur at a clock edge where state=FULL and out_ready[sel]=1.
REQ-017 in_ready SHALL be 1 when en_mask!=0 and either state=EMPTY or fire occurs this cycle; it is 0 otherwise. in_ready is combinational on en_mask, out_ready and state.
REQ-018 Target selection:
- A 3-bit round-robin pointer ptr exists.
- On load, sel SHALL be set to the first index at or after ptr (mod 8, searching upward) whose en_mask bit is 1.
- Selection SHALL depend on en_mask only, not on out_ready.
REQ-019 On load, in_data SHALL be captured into out_data and the state SHALL go to FULL, effective the next cycle (latency 1 from load to out_valid).
REQ-020 In FULL, out_valid SHALL equal the one-hot of sel. In EMPTY, out_valid SHALL be 8'h00.
REQ-021 In FULL, out_data and sel SHALL be held stable until fire. Changes to en_mask during FULL SHALL NOT alter sel.
REQ-022 On fire:
- ptr SHALL become sel+1 mod 8 (7 wraps to 0).
- sent_cnt SHALL increment by 1, wrapping from 16'hFFFF to 0.
- Without a simultaneous load, the state SHALL go to EMPTY.
REQ-023 Fire and load in the same edge:
- The state SHALL stay FULL.
- The new item SHALL be captured.
- The new sel SHALL be computed from the updated ptr (old sel+1), giving back-to-back throughput of 1 item per cycle.
REQ-024 With en_mask=0, in_ready SHALL be 0 and no load SHALL occur. An already held item SHALL remain offered to its sel until fire.
REQ-025 out_ready bits other than out_ready[sel] SHALL have no effect.
REQ-026 In EMPTY, out_data SHALL retain its last value, and sel SHALL retain its last value.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, set:
- state=EMPTY
- ptr=0
- sel=0
- out_data=0
- out_valid=0
- busy=0
- sent_cnt=0
REQ-028 A held item SHALL be discarded by reset, with no fire counted.
REQ-029 While rst_n=0, in_ready SHALL be 0.
REQ-030 After rst_n deasserts, the block SHALL accept the first load at the first rising edge where REQ-017 holds.

Verification
REQ-031 Scenario: reset, en_mask=8'hFF, out_ready=8'hFF, in_valid held 1 with data 0..9 over 10 cycles -> out_valid walks 01,02,04,...,80,01,02; data order is preserved; sent_cnt=10; one item per cycle after the first.
REQ-032 Scenario: en_mask=8'b1010_0100, out_ready all 1, 4 items -> sel=2,5,7,2.
REQ-033 Scenario: item held with sel=3, out_ready[3]=0 for 5 cycles while other bits=1 and en_mask toggles to 0 -> out_valid=8'h08 with stable data; in_ready=0; fire on the cycle out_ready[3] rises; sent_cnt +1.
REQ-034 Scenario: en_mask=0 with in_valid=1 for 4 cycles -> in_ready=0, busy=0, out_valid=0; then en_mask=8'h10 -> one load, sel=4.
REQ-035 Scenario: rst_n pulsed low mid-cycle while FULL with sel=6 -> out_valid=0, busy=0, sent_cnt=0 before the next edge; the next load gets sel=first enabled index at or after 0.
REQ-036 Scenario: preload sent_cnt to 16'hFFFF via 65535 transfers, then one more fire -> sent_cnt=0.

Source files
------------

// File: rtl/my_dispatch8.sv
// Single-slot dispatcher: holds one upstream item and offers it to one of eight
// channels, chosen round-robin among the enabled channels at load time.
module my_dispatch8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       en_mask,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [15:0]      sent_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] base;
  logic [2:0] next_sel;
  logic       found;
  logic       fire;
  logic       load;

  assign fire     = (state == FULL) && out_ready[sel];
  assign in_ready = rst_n && (en_mask != 8'h00) && ((state == EMPTY) || fire);
  assign load     = in_valid && in_ready;

  // A simultaneous fire advances the pointer in the same edge, so the search
  // must already start from the slot after the departing item.
  assign base = fire ? sel + 3'd1 : ptr;

  always_comb begin
    next_sel = base;
    found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && en_mask[base + 3'(i)]) begin
        next_sel = base + 3'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      out_data  <= '0;
      out_valid <= 8'h00;
      busy      <= 1'b0;
      sent_cnt  <= 16'h0000;
    end else begin
      if (fire) begin
        ptr      <= sel + 3'd1;
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (load) begin
        state     <= FULL;
        out_data  <= in_data;
        sel       <= next_sel;
        out_valid <= 8'b0000_0001 << next_sel;
        busy      <= 1'b1;
      end else if (fire) begin
        state     <= EMPTY;
        out_valid <= 8'h00;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_my_dispatch8.sv
// Scoreboard bench for my_dispatch8: a behavioural model predicts loads and fires
// at each falling edge, queueing expected items and checking them as they leave.
module tb_my_dispatch8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  en_mask;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] out_data;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  s;
    logic [15:0] d;
  } item_t;

  item_t      sb[$];
  int         fired_sel[$];
  bit         m_full;
  logic [2:0] m_sel;
  logic [2:0] m_ptr;
  logic [15:0] m_sent;

  my_dispatch8 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .en_mask(en_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy), .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    sb.delete();
    m_full = 1'b0;
    m_sel  = 3'd0;
    m_ptr  = 3'd0;
    m_sent = 16'h0000;
  endfunction

  // Reference model: inputs settle just after each rising edge, so the falling
  // edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    logic       fire_n;
    logic       exp_ir;
    logic [7:0] exp_ov;
    logic [2:0] ns;
    item_t      it;
    if (!rst_n) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 8'h00 || busy !== 1'b0 || sent_cnt !== 16'h0) begin
        errors++;
        $display("[TB] FAIL in_reset got ir=%b ov=%h busy=%b cnt=%h expected 0 0 0 0",
                 in_ready, out_valid, busy, sent_cnt);
      end
    end else begin
      fire_n = m_full && out_ready[m_sel];
      exp_ir = (en_mask != 8'h00) && (!m_full || fire_n);
      exp_ov = m_full ? (8'b0000_0001 << m_sel) : 8'h00;
      checks++;
      if (in_ready !== exp_ir) begin
        errors++;
        $display("[TB] FAIL in_ready got %b expected %b", in_ready, exp_ir);
      end
      checks++;
      if (out_valid !== exp_ov || busy !== m_full) begin
        errors++;
        $display("[TB] FAIL out_valid_busy got %h/%b expected %h/%b", out_valid, busy, exp_ov, m_full);
      end
      checks++;
      if (sent_cnt !== m_sent) begin
        errors++;
        $display("[TB] FAIL sent_cnt got %h expected %h", sent_cnt, m_sent);
      end
      if (m_full) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard_empty got held item expected queued entry");
        end else if (out_data !== sb[0].d || sel !== sb[0].s) begin
          errors++;
          $display("[TB] FAIL held_item got sel=%0d data=%h expected sel=%0d data=%h",
                   sel, out_data, sb[0].s, sb[0].d);
        end
      end
      if (fire_n) begin
        if (sb.size() != 0) it = sb.pop_front();
        fired_sel.push_back(int'(m_sel));
        m_sent = m_sent + 16'd1;
        m_ptr  = m_sel + 3'd1;
      end
      if (in_valid && exp_ir) begin
        ns = m_ptr;
        for (int k = 0; k < 8; k++) begin
          if (en_mask[ns]) break;
          ns = ns + 3'd1;
        end
        it.s = ns;
        it.d = in_data;
        sb.push_back(it);
        m_sel  = ns;
        m_full = 1'b1;
      end else if (fire_n) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_full || sb.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (m_full || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got full=%b queued=%0d expected idle", m_full, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0 || sent_cnt !== 16'h0 || sel !== 3'd0 ||
        out_data !== 16'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got ov=%h busy=%b cnt=%h sel=%0d data=%h ir=%b expected all 0",
               out_valid, busy, sent_cnt, sel, out_data, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int exp_s[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset();
    fired_sel.delete();
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (sent_cnt !== 16'd10) begin
      errors++;
      $display("[TB] FAIL stream_count got %0d expected 10", sent_cnt);
    end
    checks++;
    if (fired_sel.size() != 10) begin
      errors++;
      $display("[TB] FAIL stream_fires got %0d expected 10", fired_sel.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (fired_sel[i] != exp_s[i]) begin
          errors++;
          $display("[TB] FAIL stream_sel[%0d] got %0d expected %0d", i, fired_sel[i], exp_s[i]);
        end
      end
    end
  endtask

  task automatic test_sparse();
    int exp_s[4] = '{2, 5, 7, 2};
    do_reset();
    fired_sel.delete();
    en_mask   = 8'b1010_0100;
    out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h100 + 16'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (fired_sel.size() != 4) begin
      errors++;
      $display("[TB] FAIL sparse_fires got %0d expected 4", fired_sel.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fired_sel[i] != exp_s[i]) begin
          errors++;
          $display("[TB] FAIL sparse_sel[%0d] got %0d expected %0d", i, fired_sel[i], exp_s[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en_mask   = 8'h08;
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    @(posedge clk);
    #1;
    in_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      en_mask = (i % 2 == 0) ? 8'h00 : 8'h08;
      @(negedge clk);
      checks++;
      if (out_valid !== 8'h08 || out_data !== 16'hA5A5 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall got ov=%h data=%h ir=%b expected 08 a5a5 0", out_valid, out_data, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    @(posedge clk);
    #1;
    checks++;
    if (sent_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_release got cnt=%0d busy=%b expected 1 0", sent_cnt, busy);
    end
  endtask

  task automatic test_no_enable();
    do_reset();
    en_mask   = 8'h00;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 8'h00) begin
        errors++;
        $display("[TB] FAIL no_enable got ir=%b busy=%b ov=%h expected 0 0 00", in_ready, busy, out_valid);
      end
    end
    @(posedge clk);
    #1;
    en_mask = 8'h10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sel !== 3'd4 || busy !== 1'b1 || out_data !== 16'h7777) begin
      errors++;
      $display("[TB] FAIL enable_load got sel=%0d busy=%b data=%h expected 4 1 7777", sel, busy, out_data);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_mask   = 8'h40;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0 || sent_cnt !== 16'h0 || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset got ov=%h busy=%b cnt=%h sel=%0d expected 00 0 0 0",
               out_valid, busy, sent_cnt, sel);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    en_mask   = 8'b0010_0110;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 16'hCAFE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sel !== 3'd1 || out_data !== 16'hCAFE) begin
      errors++;
      $display("[TB] FAIL post_reset_sel got sel=%0d data=%h expected 1 cafe", sel, out_data);
    end
    wait_idle();
  endtask

  task automatic test_count_wrap();
    do_reset();
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    for (int i = 0; i < 65535; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (sent_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL count_full got %h expected ffff", sent_cnt);
    end
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    checks++;
    if (sent_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL count_wrap got %h expected 0000", sent_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_sparse();
    test_stall();
    test_no_enable();
    test_reset_mid();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
